// File: rtl/pipe_scheduler.sv
// pipe_scheduler: pipe-obstacle datapath sequencer for the game controller.
// Holds N_PIPE pipe slots (position + gap lower bound). In RUN the slots scroll one column
// left every SCROLL_DIV clocks. When the leftmost pipe reaches column 0 it is recycled:
// the slots shift down and a new rightmost pipe gets an LFSR-drawn gap. Score counts pipes
// passing the bird column.
// Ports:
//   clk_i         system clock, all state on posedge
//   rst_i         asynchronous active-high reset
//   start_i       1-cycle pulse: IDLE->RUN, or HALT->IDLE with reload
//   freeze_i      RUN->HALT (wins over start_i)
//   n_row_i       playfield height in rows, sampled only at recycle
//   pipes_o       slot i at [24*i+:24] = {pos, max, min}; slot 0 is leftmost
//   score_o       saturating count of pipes passed this game
//   score_tick_o  1-cycle pulse on the cycle after score_o increments' edge
//   running_o     high while in RUN
module pipe_scheduler #(
  parameter int unsigned N_PIPE     = 3,
  parameter int unsigned SCROLL_DIV = 3,
  parameter logic [7:0]  PIPE_GAP   = 8'd50,
  parameter logic [7:0]  GAP_LEN    = 8'd8,
  parameter logic [7:0]  BIRD_COL   = 8'd10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  freeze_i,
  input  logic [7:0]            n_row_i,
  output logic [24*N_PIPE-1:0]  pipes_o,
  output logic [15:0]           score_o,
  output logic                  score_tick_o,
  output logic                  running_o
);

  localparam int unsigned CntW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     score_q, score_d;
  logic            tick_q, tick_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [7:0]      pos_q [N_PIPE];
  logic [7:0]      pos_d [N_PIPE];
  logic [7:0]      min_q [N_PIPE];
  logic [7:0]      min_d [N_PIPE];

  logic            step;
  logic [7:0]      min_range;
  logic [7:0]      new_min;

  function automatic logic [7:0] init_pos(input int unsigned i);
    return 8'(PIPE_GAP * (i + 1));
  endfunction

  function automatic logic [7:0] init_min(input int unsigned i);
    return 8'(8 + 4 * i);
  endfunction

  // Gap drawn from the pre-advance LFSR value; degenerate playfield pins the gap to row 0.
  assign min_range = n_row_i - GAP_LEN;
  assign new_min   = (n_row_i <= GAP_LEN) ? 8'd0 : (lfsr_q[7:0] % min_range);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    tick_d  = 1'b0;
    // Galois form of x^16+x^14+x^13+x^11; free-running so start timing seeds the gaps.
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    pos_d   = pos_q;
    min_d   = min_q;
    step    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (freeze_i) begin
          state_d = StHalt;
        end else if (cnt_q == LastCnt) begin
          cnt_d = '0;
          step  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHalt: begin
        if (start_i) begin
          state_d = StIdle;
          cnt_d   = '0;
          score_d = '0;
          for (int unsigned i = 0; i < N_PIPE; i++) begin
            pos_d[i] = init_pos(i);
            min_d[i] = init_min(i);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (step) begin
      if (pos_q[0] != 8'd0) begin
        for (int unsigned i = 0; i < N_PIPE; i++) begin
          pos_d[i] = pos_q[i] - 8'd1;
        end
        if (pos_q[0] == BIRD_COL) begin
          score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
          tick_d  = 1'b1;
        end
      end else begin
        for (int unsigned i = 0; i + 1 < N_PIPE; i++) begin
          pos_d[i] = pos_q[i+1];
          min_d[i] = min_q[i+1];
        end
        pos_d[N_PIPE-1] = pos_q[N_PIPE-1] + PIPE_GAP;
        min_d[N_PIPE-1] = new_min;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      score_q <= '0;
      tick_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      for (int unsigned i = 0; i < N_PIPE; i++) begin
        pos_q[i] <= init_pos(i);
        min_q[i] <= init_min(i);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      tick_q  <= tick_d;
      lfsr_q  <= lfsr_d;
      for (int unsigned i = 0; i < N_PIPE; i++) begin
        pos_q[i] <= pos_d[i];
        min_q[i] <= min_d[i];
      end
    end
  end

  // max is derived, never stored, so it can never disagree with min.
  for (genvar g = 0; g < N_PIPE; g++) begin : g_pipe_out
    assign pipes_o[24*g +: 24] = {pos_q[g], min_q[g] + GAP_LEN, min_q[g]};
  end

  assign score_o      = score_q;
  assign score_tick_o = tick_q;
  assign running_o    = (state_q == StRun);

endmodule

// File: tb/tb_pipe_scheduler.sv
module tb_pipe_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, freeze, start1, freeze1;
  logic [7:0]  n_row;
  logic [71:0] pipes, pipes1;
  logic [15:0] score, score1;
  logic        score_tick, score_tick1, running, running1;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [15:0] rec;
  logic [7:0]  m1;

  always #5 clk = ~clk;

  pipe_scheduler u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .n_row_i(n_row),
    .pipes_o(pipes), .score_o(score), .score_tick_o(score_tick), .running_o(running)
  );

  pipe_scheduler #(.SCROLL_DIV(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .freeze_i(freeze1), .n_row_i(n_row),
    .pipes_o(pipes1), .score_o(score1), .score_tick_o(score_tick1), .running_o(running1)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11 Galois, seeded with 16'hACE1.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected slot contents listed rightmost first; max is checked as min+8.
  task automatic check_slots(input string tag, input logic [71:0] p,
                             input logic [7:0] p2, input logic [7:0] p1, input logic [7:0] p0,
                             input logic [7:0] n2, input logic [7:0] n1, input logic [7:0] n0);
    logic [7:0] ep [3];
    logic [7:0] en [3];
    logic [7:0] emax;
    ep[0] = p0; ep[1] = p1; ep[2] = p2;
    en[0] = n0; en[1] = n1; en[2] = n2;
    for (int s = 0; s < 3; s++) begin
      emax = en[s] + 8'd8;
      check($sformatf("%s pos%0d", tag, s), {24'd0, p[24*s+16 +: 8]}, {24'd0, ep[s]});
      check($sformatf("%s max%0d", tag, s), {24'd0, p[24*s+8 +: 8]}, {24'd0, emax});
      check($sformatf("%s min%0d", tag, s), {24'd0, p[24*s +: 8]}, {24'd0, en[s]});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; freeze = 1'b0; start1 = 1'b0; freeze1 = 1'b0; n_row = 8'd40;
    tick(2);
    rst = 1'b0;
    tick(1);

    // T1 reset values
    check_slots("reset", pipes, 8'd150, 8'd100, 8'd50, 8'd16, 8'd12, 8'd8);
    check("reset score", {16'd0, score}, 32'd0);
    check("reset running", {31'd0, running}, 32'd0);
    check("reset tick", {31'd0, score_tick}, 32'd0);

    // T2 scroll
    start = 1'b1; tick(1); start = 1'b0;
    check("run after start", {31'd0, running}, 32'd1);
    check_slots("no step at start", pipes, 8'd150, 8'd100, 8'd50, 8'd16, 8'd12, 8'd8);
    tick(3);
    check_slots("first step", pipes, 8'd149, 8'd99, 8'd49, 8'd16, 8'd12, 8'd8);

    // T3 score
    tick(119);
    check("score before 123", {16'd0, score}, 32'd0);
    check("tick before 123", {31'd0, score_tick}, 32'd0);
    tick(1);
    check("score at 123", {16'd0, score}, 32'd1);
    check("tick at 123", {31'd0, score_tick}, 32'd1);
    tick(1);
    check("tick after 123", {31'd0, score_tick}, 32'd0);
    check("score after 123", {16'd0, score}, 32'd1);

    tick(26);
    check_slots("at 150", pipes, 8'd100, 8'd50, 8'd0, 8'd16, 8'd12, 8'd8);

    // T4 recycle with n_row=40 -> range 32
    tick(2);
    rec = m_lfsr;
    tick(1);
    m1 = rec[7:0] % 8'd32;
    check_slots("recycle1", pipes, 8'd150, 8'd100, 8'd50, m1, 8'd16, 8'd12);

    n_row = 8'd8;
    tick(152);
    tick(1);
    check_slots("recycle2 n_row=8", pipes, 8'd150, 8'd100, 8'd50, 8'd0, m1, 8'd16);

    tick(217);
    check("score at 523", {16'd0, score}, 32'd3);
    check("still running", {31'd0, running}, 32'd1);

    // T1 async reset mid-cycle, no clock edge in between
    rst = 1'b1;
    #2;
    check_slots("async reset", pipes, 8'd150, 8'd100, 8'd50, 8'd16, 8'd12, 8'd8);
    check("async reset score", {16'd0, score}, 32'd0);
    check("async reset running", {31'd0, running}, 32'd0);
    tick(1);
    rst = 1'b0;
    n_row = 8'd40;
    tick(1);

    // T5 freeze at clock 60
    start = 1'b1; tick(1); start = 1'b0;
    tick(59);
    freeze = 1'b1; tick(1); freeze = 1'b0;
    check("halt running", {31'd0, running}, 32'd0);
    check_slots("frozen", pipes, 8'd131, 8'd81, 8'd31, 8'd16, 8'd12, 8'd8);
    tick(100);
    check_slots("frozen +100", pipes, 8'd131, 8'd81, 8'd31, 8'd16, 8'd12, 8'd8);
    check("frozen score", {16'd0, score}, 32'd0);
    check("frozen running", {31'd0, running}, 32'd0);

    start = 1'b1; tick(1); start = 1'b0;
    check_slots("reload", pipes, 8'd150, 8'd100, 8'd50, 8'd16, 8'd12, 8'd8);
    check("reload running", {31'd0, running}, 32'd0);

    // freeze in IDLE must not park the FSM in HALT
    freeze = 1'b1; tick(1); freeze = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    check("idle ignores freeze", {31'd0, running}, 32'd1);
    tick(5);
    check_slots("rerun", pipes, 8'd149, 8'd99, 8'd49, 8'd16, 8'd12, 8'd8);

    // start+freeze together: freeze wins, and no step on the would-be step cycle
    start = 1'b1; freeze = 1'b1; tick(1); start = 1'b0; freeze = 1'b0;
    check("start+freeze halts", {31'd0, running}, 32'd0);
    check_slots("start+freeze hold", pipes, 8'd149, 8'd99, 8'd49, 8'd16, 8'd12, 8'd8);
    start = 1'b1; tick(1); start = 1'b0;
    check_slots("reload2", pipes, 8'd150, 8'd100, 8'd50, 8'd16, 8'd12, 8'd8);
    check("reload2 running", {31'd0, running}, 32'd0);

    // T6 SCROLL_DIV=1
    start1 = 1'b1; tick(1); start1 = 1'b0;
    check("div1 running", {31'd0, running1}, 32'd1);
    check("div1 pos start", {24'd0, pipes1[23:16]}, 32'd50);
    tick(1);
    check("div1 pos +1", {24'd0, pipes1[23:16]}, 32'd49);
    tick(1);
    check("div1 pos +2", {24'd0, pipes1[23:16]}, 32'd48);
    start1 = 1'b1; tick(1); start1 = 1'b0;
    check("div1 start ignored", {31'd0, running1}, 32'd1);
    check("div1 pos +3", {24'd0, pipes1[23:16]}, 32'd47);
    check("div1 slot2 pos", {24'd0, pipes1[71:64]}, 32'd147);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
